// File: rtl/hwag_pkg.sv
// Shared types and constants for the crank-wheel sync sequencer and the
// gap comparator.
package hwag_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SEARCH,
    SYNC
  } hwag_sync_state_t;

  // Number of valid captures needed before the q0/q1/q2 window is trustworthy
  localparam logic [1:0] HWAG_VCNT_FULL = 2'd3;

  // A gap period is at least 2^HWAG_GAP_SHIFT times a regular tooth period
  localparam int HWAG_GAP_SHIFT = 1;

endpackage

// File: rtl/hwag_gap_cmp.sv
// Missing-tooth detector: flags q0 as a gap when it is at least twice both
// older periods. One extra bit keeps the doubled values from overflowing.
module hwag_gap_cmp
  import hwag_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
  output logic             gap
);

  logic [WIDTH:0] q0_w;
  logic [WIDTH:0] q1_x2;
  logic [WIDTH:0] q2_x2;

  always_comb begin
    q0_w  = {1'b0, q0};
    q1_x2 = {1'b0, q1} << HWAG_GAP_SHIFT;
    q2_x2 = {1'b0, q2} << HWAG_GAP_SHIFT;
    gap   = (q0_w >= q1_x2) && (q0_w >= q2_x2);
  end

endmodule

// File: rtl/hwag_sync_ctrl.sv
// Crank-wheel sync sequencer: period timer, capture-chain control, gap search
// and tooth counting. Optional error counter behind HWAG_SYNC_ERRCNT_EN.
module hwag_sync_ctrl
  import hwag_pkg::*;
#(
  parameter int WIDTH = 24,
  parameter int TEETH = 58,
  parameter int TW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             edge_in,
  input  logic [WIDTH-1:0] tmo_val,
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] q2,
`ifdef HWAG_SYNC_ERRCNT_EN
  input  logic             err_clr,
  output logic [7:0]       err_cnt,
`endif
  output logic [WIDTH-1:0] tim_val,
  output logic             cap_ena,
  output logic             cap_rst,
  output logic [TW-1:0]    tooth_cnt,
  output logic             sync,
  output logic             gap_pulse,
  output logic             err_pulse,
  output logic             stopped
);

  localparam logic [TW-1:0]    LAST_TOOTH = TW'(TEETH - 1);
  localparam logic [WIDTH-1:0] TIM_MAX    = '1;

  hwag_sync_state_t state, state_d;
  logic [WIDTH-1:0] tim_cnt, tim_d;
  logic [1:0]       vcnt, vcnt_d;
  logic             eval_pend, pend_d;
  logic [TW-1:0]    tooth_d;
  logic             sync_d, gap_d, err_d, stopped_d, cap_rst_d;
  logic             accepted, timeout, gap;

  hwag_gap_cmp #(.WIDTH(WIDTH)) u_gap_cmp (
    .q0  (q0),
    .q1  (q1),
    .q2  (q2),
    .gap (gap)
  );

  assign tim_val = tim_cnt;

  // While stopped the timer is frozen, so the timeout must not re-fire.
  always_comb begin
    accepted  = edge_in && (state != IDLE) && !eval_pend;
    timeout   = (tmo_val != '0) && (tim_cnt >= tmo_val) && !accepted &&
                !stopped && (state != IDLE);
    cap_ena   = edge_in & accepted;
    state_d   = state;
    tim_d     = tim_cnt;
    vcnt_d    = vcnt;
    pend_d    = accepted;
    tooth_d   = tooth_cnt;
    sync_d    = sync;
    gap_d     = 1'b0;
    err_d     = 1'b0;
    stopped_d = stopped;
    cap_rst_d = 1'b0;

    if (state == IDLE) begin
      state_d = FILL;
    end else begin
      if (accepted) begin
        tim_d     = WIDTH'(1);
        stopped_d = 1'b0;
        if (vcnt != HWAG_VCNT_FULL) vcnt_d = vcnt + 2'd1;
      end else if (!stopped && !timeout && (tim_cnt != TIM_MAX)) begin
        tim_d = tim_cnt + WIDTH'(1);
      end

      if (edge_in && eval_pend) err_d = 1'b1;

      // The capture chain shifted on the accepted edge, so q0 is fresh now
      if (eval_pend) begin
        case (state)
          FILL: begin
            if (vcnt == HWAG_VCNT_FULL) state_d = SEARCH;
          end
          SEARCH: begin
            if (gap) begin
              state_d = SYNC;
              tooth_d = '0;
              sync_d  = 1'b1;
              gap_d   = 1'b1;
            end
          end
          SYNC: begin
            if ((tooth_cnt == LAST_TOOTH) && gap) begin
              tooth_d = '0;
              gap_d   = 1'b1;
            end else if ((tooth_cnt != LAST_TOOTH) && !gap) begin
              tooth_d = tooth_cnt + TW'(1);
            end else begin
              state_d = SEARCH;
              tooth_d = '0;
              sync_d  = 1'b0;
              err_d   = 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (timeout) begin
        state_d   = FILL;
        sync_d    = 1'b0;
        tooth_d   = '0;
        vcnt_d    = '0;
        stopped_d = 1'b1;
        cap_rst_d = 1'b1;
        if (state == SYNC) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !ena) begin
      state     <= IDLE;
      tim_cnt   <= '0;
      vcnt      <= '0;
      eval_pend <= 1'b0;
      tooth_cnt <= '0;
      sync      <= 1'b0;
      gap_pulse <= 1'b0;
      err_pulse <= 1'b0;
      stopped   <= 1'b0;
      cap_rst   <= 1'b1;
    end else begin
      state     <= state_d;
      tim_cnt   <= tim_d;
      vcnt      <= vcnt_d;
      eval_pend <= pend_d;
      tooth_cnt <= tooth_d;
      sync      <= sync_d;
      gap_pulse <= gap_d;
      err_pulse <= err_d;
      stopped   <= stopped_d;
      cap_rst   <= cap_rst_d;
    end
  end

`ifdef HWAG_SYNC_ERRCNT_EN
  // Clear has priority over a coincident error pulse
  always_ff @(posedge clk) begin
    if (rst || !ena || err_clr) begin
      err_cnt <= '0;
    end else if (err_pulse && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// Bench for hwag_sync_ctrl: drives 60-2 style edge trains through a modelled
// capture chain and scores per-edge sync results from a queue.
module tb_hwag_sync_ctrl;

  localparam int WIDTH    = 24;
  localparam int TEETH    = 58;
  localparam int TW       = 6;
  localparam int M_FILL   = 1;
  localparam int M_SEARCH = 2;
  localparam int M_SYNC   = 3;

  logic             clk = 1'b0;
  logic             rst, ena, edge_in;
  logic [WIDTH-1:0] tmo_val, q0, q1, q2, tim_val;
  logic             cap_ena, cap_rst, sync, gap_pulse, err_pulse, stopped;
  logic [TW-1:0]    tooth_cnt;
`ifdef HWAG_SYNC_ERRCNT_EN
  logic             err_clr;
  logic [7:0]       err_cnt;
`endif

  typedef struct {
    logic          gap;
    logic          err;
    logic          sync;
    logic [TW-1:0] tooth;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_state, m_vcnt, m_tooth, h0, h1, h2;
  logic m_sync;

  hwag_sync_ctrl #(.WIDTH(WIDTH), .TEETH(TEETH), .TW(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .edge_in   (edge_in),
    .tmo_val   (tmo_val),
    .q0        (q0),
    .q1        (q1),
    .q2        (q2),
`ifdef HWAG_SYNC_ERRCNT_EN
    .err_clr   (err_clr),
    .err_cnt   (err_cnt),
`endif
    .tim_val   (tim_val),
    .cap_ena   (cap_ena),
    .cap_rst   (cap_rst),
    .tooth_cnt (tooth_cnt),
    .sync      (sync),
    .gap_pulse (gap_pulse),
    .err_pulse (err_pulse),
    .stopped   (stopped)
  );

  always #5 clk = ~clk;

  // Stand-in for the external three-deep capture chain
  always @(posedge clk) begin
    if (cap_rst) begin
      q0 <= '0; q1 <= '0; q2 <= '0;
    end else if (cap_ena) begin
      q2 <= q1; q1 <= q0; q0 <= tim_val;
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    m_state = M_FILL; m_vcnt = 0; m_tooth = 0; m_sync = 1'b0;
    h0 = 0; h1 = 0; h2 = 0;
  endtask

  // Edge-level reference: what the sync outputs should show two cycles later
  task automatic model_edge(input int p);
    exp_t e;
    bit   g;
    h2 = h1; h1 = h0; h0 = p;
    g = (h0 >= 2 * h1) && (h0 >= 2 * h2);
    e.gap = 1'b0; e.err = 1'b0;
    if (m_vcnt < 3) m_vcnt++;
    case (m_state)
      M_FILL:   if (m_vcnt == 3) m_state = M_SEARCH;
      M_SEARCH: if (g) begin m_state = M_SYNC; m_tooth = 0; m_sync = 1'b1; e.gap = 1'b1; end
      default: begin
        if ((m_tooth < TEETH - 1) && !g) m_tooth++;
        else if ((m_tooth == TEETH - 1) && g) begin m_tooth = 0; e.gap = 1'b1; end
        else begin m_state = M_SEARCH; m_tooth = 0; m_sync = 1'b0; e.err = 1'b1; end
      end
    endcase
    e.sync = m_sync; e.tooth = TW'(m_tooth);
    exp_q.push_back(e);
  endtask

  task automatic sb_compare(input string tag);
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({gap_pulse, err_pulse, sync, tooth_cnt} !== {e.gap, e.err, e.sync, e.tooth}) begin
        n_errors++;
        $display("[TB] FAIL %s: got gap=%0b err=%0b sync=%0b tooth=%0d, required gap=%0b err=%0b sync=%0b tooth=%0d",
                 tag, gap_pulse, err_pulse, sync, tooth_cnt, e.gap, e.err, e.sync, e.tooth);
      end
    end
  endtask

  task automatic issue_edge(input int p, input bit chk_tim);
    @(negedge clk);
    edge_in = 1'b1;
    #1;
    n_checks++;
    if (cap_ena !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL cap_ena_on_edge: got %0b, required 1", cap_ena);
    end
    if (chk_tim) begin
      n_checks++;
      if (tim_val !== WIDTH'(p)) begin
        n_errors++;
        $display("[TB] FAIL tim_val_at_edge: got %0d, required %0d", tim_val, p);
      end
    end
    model_edge(p);
  endtask

  // Entered at the negedge of the previous edge cycle; p >= 3
  task automatic send_edge(input int p);
    @(negedge clk);
    edge_in = 1'b0;
    #1;
    n_checks++;
    if (cap_ena !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL cap_ena_one_cycle: got %0b, required 0", cap_ena);
    end
    @(negedge clk);
    sb_compare("edge_result");
    repeat (p - 3) @(negedge clk);
    issue_edge(p, 1'b1);
  endtask

  task automatic drain();
    @(negedge clk);
    edge_in = 1'b0;
    @(negedge clk);
    sb_compare("edge_result_drain");
  endtask

  task automatic test_reset();
    rst = 1'b1; ena = 1'b1; edge_in = 1'b1; tmo_val = '0;
`ifdef HWAG_SYNC_ERRCNT_EN
    err_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({tim_val, cap_ena, cap_rst, tooth_cnt, sync, gap_pulse, err_pulse, stopped} !==
        {24'd0, 1'b0, 1'b1, 6'd0, 4'b0000}) begin
      n_errors++;
      $display("[TB] FAIL reset_outputs: got tim=%0d cap_ena=%0b cap_rst=%0b tooth=%0d sync=%0b gap=%0b err=%0b stopped=%0b, required cap_rst=1 rest 0",
               tim_val, cap_ena, cap_rst, tooth_cnt, sync, gap_pulse, err_pulse, stopped);
    end
`ifdef HWAG_SYNC_ERRCNT_EN
    n_checks++;
    if (err_cnt !== 8'd0) begin
      n_errors++;
      $display("[TB] FAIL reset_err_cnt: got %0d, required 0", err_cnt);
    end
`endif
    edge_in = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (cap_rst !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL cap_rst_after_reset: got %0b, required 0", cap_rst);
    end
  endtask

  task automatic test_fill();
    repeat (50) @(negedge clk);
    issue_edge(100, 1'b0);
    for (int i = 0; i < 4; i++) send_edge(100);
  endtask

  task automatic test_sync_lock();
    for (int i = 0; i < 57; i++) send_edge(100);
    send_edge(300);
    for (int i = 0; i < 57; i++) send_edge(100);
    send_edge(300);
  endtask

  task automatic test_early_gap();
    for (int i = 0; i < 20; i++) send_edge(100);
    send_edge(300);
    for (int i = 0; i < 57; i++) send_edge(100);
    send_edge(300);
  endtask

  task automatic test_missing_gap();
    for (int i = 0; i < 57; i++) send_edge(100);
    send_edge(100);
    send_edge(300);
    for (int i = 0; i < 3; i++) send_edge(100);
  endtask

  task automatic test_timeout();
    tmo_val = WIDTH'(1000);
    drain();
    repeat (998) @(negedge clk);
    n_checks++;
    if ({stopped, sync} !== 2'b01) begin
      n_errors++;
      $display("[TB] FAIL timeout_early: got stopped=%0b sync=%0b, required stopped=0 sync=1", stopped, sync);
    end
    @(negedge clk);
    n_checks++;
    if ({stopped, cap_rst, err_pulse, sync, tooth_cnt} !== {4'b1110, 6'd0}) begin
      n_errors++;
      $display("[TB] FAIL timeout_fire: got stopped=%0b cap_rst=%0b err=%0b sync=%0b tooth=%0d, required 1 1 1 0 0",
               stopped, cap_rst, err_pulse, sync, tooth_cnt);
    end
    @(negedge clk);
    n_checks++;
    if ({stopped, cap_rst, err_pulse, tim_val} !== {3'b100, 24'd1000}) begin
      n_errors++;
      $display("[TB] FAIL timeout_after: got stopped=%0b cap_rst=%0b err=%0b tim=%0d, required 1 0 0 1000",
               stopped, cap_rst, err_pulse, tim_val);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if ({stopped, tim_val} !== {1'b1, 24'd1000}) begin
      n_errors++;
      $display("[TB] FAIL timeout_hold: got stopped=%0b tim=%0d, required 1 1000", stopped, tim_val);
    end
    model_reset();
    issue_edge(1000, 1'b1);
    @(negedge clk);
    edge_in = 1'b0;
    n_checks++;
    if (stopped !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL stopped_clear: got %0b, required 0", stopped);
    end
    @(negedge clk);
    sb_compare("restart_edge");
    repeat (97) @(negedge clk);
    issue_edge(100, 1'b1);
    send_edge(100);
    send_edge(100);
    send_edge(300);
    send_edge(100);
    send_edge(100);
    tmo_val = '0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    send_edge(100);
    @(negedge clk);
    #1;
    n_checks++;
    if (cap_ena !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL dropped_edge_cap_ena: got %0b, required 0", cap_ena);
    end
    e = exp_q.pop_back();
    e.err = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    edge_in = 1'b0;
    sb_compare("dropped_edge");
    repeat (97) @(negedge clk);
    issue_edge(100, 1'b1);
  endtask

  task automatic test_ena_drop();
    drain();
    n_checks++;
    if (sync !== m_sync) begin
      n_errors++;
      $display("[TB] FAIL sync_before_ena_drop: got %0b, required %0b", sync, m_sync);
    end
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({tim_val, cap_ena, cap_rst, tooth_cnt, sync, gap_pulse, err_pulse, stopped} !==
        {24'd0, 1'b0, 1'b1, 6'd0, 4'b0000}) begin
      n_errors++;
      $display("[TB] FAIL ena_drop_outputs: got tim=%0d cap_ena=%0b cap_rst=%0b tooth=%0d sync=%0b gap=%0b err=%0b stopped=%0b, required cap_rst=1 rest 0",
               tim_val, cap_ena, cap_rst, tooth_cnt, sync, gap_pulse, err_pulse, stopped);
    end
    @(negedge clk);
    ena = 1'b1;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (cap_rst !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL cap_rst_after_ena: got %0b, required 0", cap_rst);
    end
  endtask

`ifdef HWAG_SYNC_ERRCNT_EN
  task automatic test_err_cnt();
    edge_in = 1'b1;
    repeat (640) @(negedge clk);
    n_checks++;
    if (err_cnt !== 8'd255) begin
      n_errors++;
      $display("[TB] FAIL err_cnt_saturate: got %0d, required 255", err_cnt);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    edge_in = 1'b0;
    n_checks++;
    if (err_cnt !== 8'd0) begin
      n_errors++;
      $display("[TB] FAIL err_cnt_clear: got %0d, required 0", err_cnt);
    end
  endtask
`endif

  initial begin
    $display("[TB] hwag_sync_ctrl bench start");
    test_reset();
    test_fill();
    test_sync_lock();
    test_early_gap();
    test_missing_gap();
    test_timeout();
    test_back_to_back();
    test_ena_drop();
`ifdef HWAG_SYNC_ERRCNT_EN
    test_err_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
